// File: rtl/reg_file_pkg.sv
// Shared defaults, word types and helpers for the
// multi-read register file and its pending-write scoreboard.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  // Width needed to count 0..max_pend outstanding writes
  function automatic int cnt_w(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback/debug bundle of the register file.
// The pipeline side drives master, the register file is slave.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra_addr;
  logic [DATA_W-1:0] ra_dout;
  logic              ra_busy;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_dout;
  logic              rb_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_ready;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_dout;
  logic              err_underflow;

  modport master (
    output ra_addr, rb_addr,
    output wr_en, wr_addr, wr_data,
    output iss_en, iss_addr, dbg_addr,
    input  ra_dout, ra_busy,
    input  rb_dout, rb_busy,
    input  iss_ready, dbg_dout,
    input  err_underflow
  );

  modport slave (
    input  ra_addr, rb_addr,
    input  wr_en, wr_addr, wr_data,
    input  iss_en, iss_addr, dbg_addr,
    output ra_dout, ra_busy,
    output rb_dout, rb_busy,
    output iss_ready, dbg_dout,
    output err_underflow
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters: issue increments,
// writeback retires, busy lookups and sticky underflow flag.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_PEND = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_iss_en,
  input  logic [ADDR_W-1:0] i_iss_addr,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic              o_iss_ready,
  output logic              o_a_busy,
  output logic              o_b_busy,
  output logic              o_err_underflow
);

  localparam int CW    = cnt_w(MAX_PEND);
  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [CW-1:0] cnt_t;

  cnt_t r_cnt [DEPTH];
  logic r_err;

  logic w_iss_zero;
  logic w_wr_zero;
  logic w_same;
  cnt_t w_wr_cnt;
  cnt_t w_iss_cnt;
  logic w_dec;
  logic w_uf;
  logic w_inc;
  cnt_t w_a_cnt;
  cnt_t w_b_cnt;
  logic w_a_drop;
  logic w_b_drop;

  assign w_iss_zero = (ZERO_REG != 0) && (i_iss_addr == '0);
  assign w_wr_zero  = (ZERO_REG != 0) && (i_wr_addr == '0);
  assign w_same     = i_wr_addr == i_iss_addr;
  assign w_wr_cnt   = r_cnt[i_wr_addr];
  assign w_iss_cnt  = r_cnt[i_iss_addr];

  assign w_dec = i_wr_en && !w_wr_zero && (w_wr_cnt != '0);
  assign w_uf  = i_wr_en && !w_wr_zero && (w_wr_cnt == '0);

  // A same-cycle retire to a full register frees a slot
  assign o_iss_ready = rst || w_iss_zero ||
                       (w_iss_cnt != CW'(MAX_PEND)) ||
                       (w_dec && w_same);

  assign w_inc = i_iss_en && o_iss_ready && !w_iss_zero;

  assign w_a_cnt  = r_cnt[i_a_addr];
  assign w_b_cnt  = r_cnt[i_b_addr];
  assign w_a_drop = (BYPASS != 0) && i_wr_en &&
                    (i_wr_addr == i_a_addr) &&
                    (w_a_cnt == CW'(1)) &&
                    !(i_iss_en && i_iss_addr == i_a_addr);
  assign w_b_drop = (BYPASS != 0) && i_wr_en &&
                    (i_wr_addr == i_b_addr) &&
                    (w_b_cnt == CW'(1)) &&
                    !(i_iss_en && i_iss_addr == i_b_addr);

  assign o_a_busy        = (w_a_cnt != '0) && !w_a_drop;
  assign o_b_busy        = (w_b_cnt != '0) && !w_b_drop;
  assign o_err_underflow = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_cnt[i] <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_inc && !(w_dec && w_same))
        r_cnt[i_iss_addr] <= w_iss_cnt + CW'(1);
      if (w_dec && !(w_inc && w_same))
        r_cnt[i_wr_addr] <= w_wr_cnt - CW'(1);
      if (w_uf)
        r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read register file with write-through bypass,
// debug read port and a pending-write scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int              DATA_W   = DATA_W_DEF,
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int              ZERO_REG = 1,
  parameter int              BYPASS   = 1,
  parameter int              MAX_PEND = 3
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_wr_zero;

  assign w_wr_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= RST_VAL;
    end else if (bus.wr_en && !w_wr_zero) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Zero register wins over bypass, bypass over storage
  function automatic logic [DATA_W-1:0] sel(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              byp,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if ((ZERO_REG != 0) && (a == '0))
      return '0;
    if (byp && we && (wa == a))
      return wd;
    return stored;
  endfunction

  assign bus.ra_dout  = sel(bus.ra_addr,
                            r_mem[bus.ra_addr],
                            BYPASS != 0, bus.wr_en,
                            bus.wr_addr, bus.wr_data);
  assign bus.rb_dout  = sel(bus.rb_addr,
                            r_mem[bus.rb_addr],
                            BYPASS != 0, bus.wr_en,
                            bus.wr_addr, bus.wr_data);
  assign bus.dbg_dout = sel(bus.dbg_addr,
                            r_mem[bus.dbg_addr],
                            1'b0, bus.wr_en,
                            bus.wr_addr, bus.wr_data);

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .MAX_PEND (MAX_PEND),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk             (clk),
    .rst             (rst),
    .i_iss_en        (bus.iss_en),
    .i_iss_addr      (bus.iss_addr),
    .i_wr_en         (bus.wr_en),
    .i_wr_addr       (bus.wr_addr),
    .i_a_addr        (bus.ra_addr),
    .i_b_addr        (bus.rb_addr),
    .o_iss_ready     (bus.iss_ready),
    .o_a_busy        (bus.ra_busy),
    .o_b_busy        (bus.rb_busy),
    .o_err_underflow (bus.err_underflow)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: stimulus queues expectations,
// a monitor compares them against the live outputs.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int K_RA   = 0;
  localparam int K_RB   = 1;
  localparam int K_DBG  = 2;
  localparam int K_RAB  = 3;
  localparam int K_RBB  = 4;
  localparam int K_RDY  = 5;
  localparam int K_ERR  = 6;

  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] v;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_sb #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .RST_VAL  (32'd1),
    .ZERO_REG (1),
    .BYPASS   (1),
    .MAX_PEND (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act(input int k);
    case (k)
      K_RA:    return bus.ra_dout;
      K_RB:    return bus.rb_dout;
      K_DBG:   return bus.dbg_dout;
      K_RAB:   return {31'd0, bus.ra_busy};
      K_RBB:   return {31'd0, bus.rb_busy};
      K_RDY:   return {31'd0, bus.iss_ready};
      default: return {31'd0, bus.err_underflow};
    endcase
  endfunction

  // Monitor: also wakes on rst so reset effects are seen between edges
  always begin
    @(negedge clk or posedge rst);
    #1;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = act(e.kind);
      total++;
      if (e.cyc != cyc || a !== e.v) begin
        bad++;
        $display("FAIL %s: got %h want %h (cyc %0d/%0d)",
                 e.nm, a, e.v, cyc, e.cyc);
      end
    end
  end

  task automatic ex(input string nm, input int k,
                    input logic [31:0] v);
    q.push_back('{nm, k, v, cyc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [4:0] a,
                    input logic [31:0] d);
    bus.wr_en   = en;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic iss(input logic en, input logic [4:0] a);
    bus.iss_en   = en;
    bus.iss_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    bus.ra_addr  = 5'd5;
    bus.rb_addr  = 5'd0;
    bus.dbg_addr = 5'd5;
    wr(1'b0, 5'd0, 32'd0);
    iss(1'b0, 5'd3);

    step();
    ex("rst_ra5",   K_RA,  32'd1);
    ex("rst_rb0",   K_RB,  32'd0);
    ex("rst_dbg5",  K_DBG, 32'd1);
    ex("rst_busy",  K_RAB, 32'd0);
    ex("rst_rdy",   K_RDY, 32'd1);

    step();
    rst = 1'b0;
    iss(1'b1, 5'd7);

    step();
    iss(1'b0, 5'd7);
    bus.ra_addr  = 5'd7;
    bus.dbg_addr = 5'd7;
    wr(1'b1, 5'd7, 32'hDEAD_BEEF);
    ex("byp_ra",    K_RA,  32'hDEAD_BEEF);
    ex("dbg_old",   K_DBG, 32'd1);
    ex("drop_busy", K_RAB, 32'd0);
    ex("wr_err",    K_ERR, 32'd0);

    step();
    wr(1'b0, 5'd7, 32'd0);
    ex("post_ra",   K_RA,  32'hDEAD_BEEF);
    ex("post_dbg",  K_DBG, 32'hDEAD_BEEF);

    bus.rb_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      iss(1'b1, 5'd3);
      ex($sformatf("iss_rdy%0d", i), K_RDY, 32'd1);
    end

    step();
    ex("iss_full",  K_RDY, 32'd0);
    ex("full_busy", K_RBB, 32'd1);

    step();
    wr(1'b1, 5'd3, 32'h33);
    ex("iss_wb_rdy", K_RDY, 32'd1);
    ex("iss_wb_rb",  K_RB,  32'h33);
    ex("iss_wb_bsy", K_RBB, 32'd1);

    step();
    iss(1'b0, 5'd3);
    wr(1'b1, 5'd3, 32'h34);
    ex("wb1_busy",  K_RBB, 32'd1);
    ex("wb1_rdy",   K_RDY, 32'd1);

    step();
    wr(1'b1, 5'd3, 32'h35);
    ex("wb2_busy",  K_RBB, 32'd1);

    step();
    wr(1'b1, 5'd3, 32'h36);
    ex("wb3_busy",  K_RBB, 32'd0);
    ex("wb3_rb",    K_RB,  32'h36);

    step();
    wr(1'b0, 5'd3, 32'd0);
    ex("idle_busy", K_RBB, 32'd0);
    ex("idle_rb",   K_RB,  32'h36);
    ex("idle_err",  K_ERR, 32'd0);

    step();
    bus.ra_addr  = 5'd0;
    bus.rb_addr  = 5'd0;
    bus.dbg_addr = 5'd0;
    wr(1'b1, 5'd0, 32'h55);
    iss(1'b1, 5'd0);
    ex("z_ra_byp",  K_RA,  32'd0);
    ex("z_rdy",     K_RDY, 32'd1);
    ex("z_busy",    K_RAB, 32'd0);

    step();
    wr(1'b0, 5'd0, 32'd0);
    iss(1'b0, 5'd0);
    ex("z_rb",      K_RB,  32'd0);
    ex("z_dbg",     K_DBG, 32'd0);
    ex("z_busy2",   K_RAB, 32'd0);
    ex("z_err",     K_ERR, 32'd0);

    step();
    bus.ra_addr = 5'd9;
    wr(1'b1, 5'd9, 32'h99);
    ex("uf_ra",     K_RA,  32'h99);
    ex("uf_err0",   K_ERR, 32'd0);

    step();
    wr(1'b0, 5'd9, 32'd0);
    bus.dbg_addr = 5'd9;
    ex("uf_dbg",    K_DBG, 32'h99);
    ex("uf_err1",   K_ERR, 32'd1);

    step();
    step();
    ex("uf_sticky", K_ERR, 32'd1);

    step();
    iss(1'b1, 5'd4);
    step();
    iss(1'b1, 5'd4);

    step();
    iss(1'b0, 5'd4);
    bus.ra_addr = 5'd4;
    bus.rb_addr = 5'd7;
    wr(1'b1, 5'd4, 32'h44);
    ex("pre_busy",  K_RAB, 32'd1);
    ex("pre_ra",    K_RA,  32'h44);

    @(negedge clk);
    #2;
    ex("mr_ra_byp", K_RA,  32'h44);
    ex("mr_rb",     K_RB,  32'd1);
    ex("mr_dbg",    K_DBG, 32'd1);
    ex("mr_busy",   K_RAB, 32'd0);
    ex("mr_err",    K_ERR, 32'd0);
    ex("mr_rdy",    K_RDY, 32'd1);
    rst = 1'b1;

    step();
    wr(1'b0, 5'd4, 32'd0);
    ex("mr_ra",     K_RA,  32'd1);
    ex("mr_busy2",  K_RAB, 32'd0);

    step();
    rst = 1'b0;
    ex("post_ra4",  K_RA,  32'd1);
    ex("post_bsy",  K_RAB, 32'd0);
    ex("post_err",  K_ERR, 32'd0);
    ex("post_rdy",  K_RDY, 32'd1);

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read register file with a write-through bypass and a per-register pending-write scoreboard. It replaces the fixed 32x32 register file in the pipelined CPU datapath. Decode reads operands and marks destinations pending at issue. Writeback writes results and retires pending entries. Busy flags drive the hazard/stall logic.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2**ADDR_W
- RST_VAL, 0, value loaded into every register on reset
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports
- MAX_PEND, 3, maximum outstanding writes per register; counter width = clog2(MAX_PEND+1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset rst, asynchronous, active-high
- ra_addr  in  ADDR_W  read port A address
- ra_dout  out  DATA_W  read port A data (combinational)
- ra_busy  out  1  register at ra_addr has pending writes
- rb_addr  in  ADDR_W  read port B address
- rb_dout  out  DATA_W  read port B data (combinational)
- rb_busy  out  1  register at rb_addr has pending writes
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  issue strobe; marks iss_addr pending
- iss_addr  in  ADDR_W  issue destination
- iss_ready  out  1  the issue to iss_addr is accepted this cycle
- dbg_addr  in  ADDR_W  debug read address, no bypass
- dbg_dout  out  DATA_W  debug read data
- err_underflow  out  1  sticky; a writeback hit a register with pending count 0

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits. The write commits on the clk edge when wr_en=1.
- Read data, in priority order:
  - If ZERO_REG=1 and addr=0, the result is 0.
  - Else if BYPASS=1, wr_en=1 and wr_addr=addr, the result is wr_data.
  - Else the result is the stored value.
- dbg_dout ignores BYPASS but honours ZERO_REG.
- Scoreboard: each register has a pending counter cnt[i].
  - iss_ready = (cnt[iss_addr] != MAX_PEND) or cnt[iss_addr] is decremented this cycle. It is always 1 for address 0 when ZERO_REG=1.
  - On an edge, the issue increments cnt[iss_addr] when iss_en=1 and iss_ready=1.
  - On an edge, the writeback decrements cnt[wr_addr] when wr_en=1 and cnt[wr_addr] > 0.
  - Issue and writeback to the same address in the same cycle: the count is unchanged; data is still written.
  - A writeback with cnt=0 still writes the data, leaves cnt at 0 and sets err_underflow.
  - The zero register (ZERO_REG=1) never increments, never decrements and never sets err_underflow.
- Busy: ra_busy = cnt[ra_addr] != 0, except when a same-cycle writeback drops the count to 0. That case is wr_en=1, wr_addr=ra_addr, cnt=1 and no same-address issue; ra_busy is then 0. The same rule applies to rb_busy. With BYPASS=0 this exception is disabled.
- An issue rejected by iss_ready=0 has no effect; the source holds iss_en and retries.

## Timing
- Reads, busy and iss_ready are combinational, with zero latency.
- A write is visible through the stored value on the cycle after the edge, or in the same cycle via the bypass.
- Scoreboard update latency: 1 edge.
- Reset, asynchronous, takes effect immediately mid-operation. It sets all registers to RST_VAL, all cnt to 0 and err_underflow to 0.
- Output values under reset (combinational, so they track the current inputs):
  - ra_dout, rb_dout and dbg_dout are RST_VAL, or 0 for address 0 with ZERO_REG=1, except that the A/B ports show wr_data when a same-address bypass is active.
  - ra_busy = rb_busy = 0.
  - iss_ready = 1.
- A write or issue arriving during reset is discarded.
- err_underflow clears only on rst.

## Structure
- Package reg_file_pkg holds:
  - the DATA_W/ADDR_W defaults
  - a cnt_w(MAX_PEND) function
  - the typedefs for the address and data words
- Sub-module reg_scoreboard holds the counters array, iss_ready, the busy lookups for two addresses and err_underflow. The top holds the storage, bypass muxes and debug port.

## Test plan
- Reset with RST_VAL=1: read addr 5 gives 1; read addr 0 gives 0; busy=0; iss_ready=1.
- Write 0xDEADBEEF to addr 7 with ra_addr=7 in the same cycle: ra_dout=0xDEADBEEF before the edge (BYPASS=1) and after it. dbg_dout shows the old value until the edge.
- Scoreboard: issue addr 3 three times, then a 4th issue gives iss_ready=0 with cnt held at 3. Issue plus writeback to 3 in one cycle leaves cnt=3 and iss_ready=1. Three writebacks then give rb_busy=0 on the cycle of the third.
- Write 0x55 to addr 0 and issue to addr 0: reads give 0, busy stays 0, err_underflow stays 0.
- Writeback to addr 9 with cnt=0: data is written and err_underflow=1 and stays 1 until rst.
- Assert rst mid-stream with cnt[4]=2 and a pending write: all registers return to RST_VAL, cnt=0 and busy drops immediately without a clock edge.
